mem_arb_ctrl: RTL and testbench
===============================

MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 SHALL have parameter DataWidth, default 32, data bus width in bits; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have parameter AddrWidth, default 32, byte-address width in bits.
REQ-003 SHALL have parameter NumPorts, default 2, number of requester ports; legal range is 1 to 8.
REQ-004 SHALL have parameter DepthWords, default 256, backing storage depth in DataWidth words.
REQ-005 SHALL have parameter WaitStates, default 1, number of access cycles between grant and response; legal range is 0 to 15.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port req, input, NumPorts bits: per-port request, held high until granted.
REQ-009 SHALL have port write, input, NumPorts bits: per-port direction, 1 = write, 0 = read.
REQ-010 SHALL have port addr, input, NumPorts*AddrWidth bits: per-port byte address, with port i at slice i.
REQ-011 SHALL have port wData, input, NumPorts*DataWidth bits: per-port write data.
REQ-012 SHALL have port strb, input, NumPorts*(DataWidth/8) bits: per-port byte-lane write enables.
REQ-013 SHALL have port gnt, output, NumPorts bits: one-hot grant, combinational, valid in the grant cycle.
REQ-014 SHALL have port done, output, NumPorts bits: one-hot, one-cycle completion pulse.
REQ-015 SHALL have port resp, output, 2 bits: 2'b00 OKAY or 2'b01 ERROR, valid while done is nonzero.
REQ-016 SHALL have port rData, output, DataWidth bits: read data, valid while done is nonzero.
REQ-017 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-019 In IDLE with req nonzero, the block SHALL assert gnt for exactly one port chosen round-robin, latch that port's addr, write, wData and strb, and move to ACCESS; if WaitStates = 0 it SHALL move to RESP instead.
REQ-020 Round-robin priority SHALL start at the port after the last granted port; after reset port 0 has highest priority.
REQ-021 ACCESS SHALL last exactly WaitStates cycles, counted by a down-counter, then the FSM SHALL move to RESP.
REQ-022 In RESP, done[granted port] SHALL be 1 for one cycle together with resp and rData, then the FSM SHALL return to IDLE.
REQ-023 Grant-to-done latency SHALL be exactly 1 + WaitStates cycles.
REQ-024 The next grant SHALL occur no earlier than the cycle after RESP, giving a minimum period of 2 + WaitStates cycles per transfer.
REQ-025 The word index SHALL be addr >> log2(DataWidth/8).
REQ-026 A transfer SHALL be OKAY only if the word index is below DepthWords and the low log2(DataWidth/8) address bits are zero; otherwise it SHALL be ERROR.
REQ-027 An ERROR transfer SHALL modify no storage and SHALL return rData = 0.
REQ-028 An OKAY write SHALL update only the byte lanes whose strb bit is 1, committed on the clock edge that enters RESP.
REQ-029 An OKAY write SHALL return rData = 0.
REQ-030 An OKAY read SHALL return the stored word.
REQ-031 Outside RESP, done SHALL be 0, resp SHALL be 2'b00 and rData SHALL be 0.
REQ-032 gnt SHALL be 0 outside IDLE, regardless of req.
REQ-033 Requests arriving while busy SHALL wait with no loss, because the requester holds req until gnt.
REQ-034 A write followed by a read to the same word SHALL return the new data (no stale read).
REQ-035 A port deasserting req before grant SHALL simply not be granted; this is not an error.

Reset
REQ-036 When reset is high at a clock edge, the FSM SHALL enter IDLE, the round-robin pointer SHALL return to port 0 and the wait counter SHALL clear.
REQ-037 Immediately after that reset edge, all outputs SHALL be 0 (gnt follows REQ-019 from IDLE).
REQ-038 Reset during ACCESS or RESP SHALL abort the transfer with no storage write and no done pulse.
REQ-039 Storage contents SHALL NOT be reset.
REQ-040 gnt SHALL be 0 while reset is high.

Verification
REQ-041 With NumPorts=2 and WaitStates=1, port 0 writes 0xDEADBEEF to address 0x10 with strb=4'hF, then reads it back -> done[0] two cycles after each grant, resp=00, read rData=0xDEADBEEF.
REQ-042 Partial write: after REQ-041, write 0x000000AA to 0x10 with strb=4'b0001, then read -> rData=0xDEADBEAA.
REQ-043 Ports 0 and 1 request continuously -> grants alternate 0,1,0,1, each port completes every 6 cycles, and no port is starved.
REQ-044 Read of address DepthWords*4, and a write to 0x11 -> resp=01 and rData=0 for both, and a later read of 0x10 shows storage unchanged.
REQ-045 Reset asserted in the ACCESS cycle of a write to 0x20 with data 0x12345678 -> no done pulse, busy=0 after the edge, and a subsequent read of 0x20 returns the old value.
REQ-046 WaitStates=0 build -> done is asserted in the cycle after grant and back-to-back transfers complete every 2 cycles.

Source files
------------

// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: round-robin arbiter in front of a single-ported word memory with fixed wait states.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   req/write/addr/wData/strb : per-port request, direction, byte address, write data, byte enables
//   gnt                   : one-hot combinational grant, only in IDLE
//   done/resp/rData       : one-cycle completion pulse with status and read data, only in RESP
//   busy                  : high whenever the FSM is not in IDLE
module mem_arb_ctrl #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int NumPorts   = 2,
  parameter int DepthWords = 256,
  parameter int WaitStates = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NumPorts-1:0]               req,
  input  logic [NumPorts-1:0]               write,
  input  logic [NumPorts*AddrWidth-1:0]     addr,
  input  logic [NumPorts*DataWidth-1:0]     wData,
  input  logic [NumPorts*(DataWidth/8)-1:0] strb,
  output logic [NumPorts-1:0]               gnt,
  output logic [NumPorts-1:0]               done,
  output logic [1:0]                        resp,
  output logic [DataWidth-1:0]              rData,
  output logic                              busy
);
  localparam int NB = DataWidth / 8;
  localparam int LB = $clog2(NB);
  localparam int PW = NumPorts > 1 ? $clog2(NumPorts) : 1;
  localparam int IW = DepthWords > 1 ? $clog2(DepthWords) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, nxt;
  logic [PW-1:0] ptr, sel, port;
  logic found, wr_q, cur_wr, cur_ok, commit;
  logic [3:0] cnt;
  logic [AddrWidth-1:0] addr_q, cur_addr, cur_idx;
  logic [DataWidth-1:0] wdata_q, cur_wdata;
  logic [NB-1:0] strb_q, cur_strb;
  logic [DataWidth-1:0] mem [DepthWords];
  // ptr is the highest-priority port: one past the last granted port
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int k = 0; k < NumPorts; k++)
      if (!found && req[(int'(ptr) + k) % NumPorts]) begin
        sel = PW'((int'(ptr) + k) % NumPorts);
        found = 1'b1;
      end
  end
  // In IDLE the transfer being granted is still on the inputs; afterwards it is the latched copy.
  // This lets a zero-wait-state build commit its write on the grant edge.
  assign cur_addr  = state == IDLE ? addr[sel*AddrWidth +: AddrWidth] : addr_q;
  assign cur_wdata = state == IDLE ? wData[sel*DataWidth +: DataWidth] : wdata_q;
  assign cur_strb  = state == IDLE ? strb[sel*NB +: NB] : strb_q;
  assign cur_wr    = state == IDLE ? write[sel] : wr_q;
  assign cur_idx   = cur_addr >> LB;
  assign cur_ok    = ((cur_addr & AddrWidth'(NB - 1)) == '0) && (cur_idx < AddrWidth'(DepthWords));
  // write lands on the edge that enters RESP; reset on that edge suppresses it
  assign commit = !reset && cur_ok && cur_wr &&
                  (state == ACCESS ? cnt == 4'd0 : state == IDLE && found && WaitStates == 0);
  always_comb begin
    nxt = state == IDLE   ? (found ? (WaitStates == 0 ? RESP : ACCESS) : IDLE) :
          state == ACCESS ? (cnt == 4'd0 ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && found) begin
        port <= sel;
        wr_q <= write[sel];
        addr_q <= addr[sel*AddrWidth +: AddrWidth];
        wdata_q <= wData[sel*DataWidth +: DataWidth];
        strb_q <= strb[sel*NB +: NB];
        ptr <= int'(sel) == NumPorts - 1 ? '0 : sel + 1'b1;
        cnt <= 4'(WaitStates - 1);
      end else if (state == ACCESS) cnt <= cnt - 1'b1;
    end
  always_ff @(posedge clk)
    if (commit)
      for (int b = 0; b < NB; b++)
        if (cur_strb[b]) mem[cur_idx[IW-1:0]][b*8 +: 8] <= cur_wdata[b*8 +: 8];
  assign gnt   = state == IDLE && found && !reset ? NumPorts'(1) << sel : '0;
  assign done  = state == RESP ? NumPorts'(1) << port : '0;
  assign resp  = {1'b0, state == RESP && !cur_ok};
  assign rData = state == RESP && cur_ok && !cur_wr ? mem[cur_idx[IW-1:0]] : '0;
  assign busy  = state != IDLE;
endmodule

// File: tb/tb_mem_arb_ctrl.sv
// tb_mem_arb_ctrl: directed and random checks of mem_arb_ctrl against a transfer-level model.
module tb_mem_arb_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] req = '0, write = '0, gnt, done, resp;
  logic [63:0] addr = '0, wData = '0;
  logic [7:0] strb = '0;
  logic [31:0] rData;
  logic busy;
  logic [1:0] req1 = '0, write1 = '0, gnt1, done1, resp1;
  logic [63:0] addr1 = '0, wData1 = '0;
  logic [7:0] strb1 = '0;
  logic [31:0] rData1;
  logic busy1;
  int total = 0, bad = 0;
  int cyc = 0, due = 0, last = 1, gport = -1, pp = 0;
  bit inflight = 1'b0, pwr = 1'b0;
  logic [31:0] pa = '0, pd = '0, obs_rd = '0;
  logic [3:0] ps = '0;
  logic [31:0] mm [256];
  always #5 clk = ~clk;
  mem_arb_ctrl #(.DataWidth(32), .AddrWidth(32), .NumPorts(2), .DepthWords(256), .WaitStates(1)) u0 (
    .clk(clk), .reset(reset), .req(req), .write(write), .addr(addr), .wData(wData), .strb(strb),
    .gnt(gnt), .done(done), .resp(resp), .rData(rData), .busy(busy));
  mem_arb_ctrl #(.DataWidth(32), .AddrWidth(32), .NumPorts(2), .DepthWords(256), .WaitStates(0)) u1 (
    .clk(clk), .reset(reset), .req(req1), .write(write1), .addr(addr1), .wData(wData1), .strb(strb1),
    .gnt(gnt1), .done(done1), .resp(resp1), .rData(rData1), .busy(busy1));
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  // One clock of u0: predict outputs from the model, compare at negedge, then advance the model.
  // A transfer granted in cycle c completes in cycle c+2; writes apply to the model at completion.
  task automatic cyc_step();
    logic [1:0] eg, ed, er;
    logic [31:0] erd;
    int g, w;
    bit ok;
    eg = '0; ed = '0; er = '0; erd = '0; g = -1;
    @(negedge clk);
    if (inflight && cyc == due) begin
      w = int'(pa >> 2);
      ok = pa[1:0] == 2'b00 && w < 256;
      ed = 2'(1 << pp);
      er = ok ? 2'b00 : 2'b01;
      if (ok && !pwr) erd = mm[w];
      if (ok && pwr)
        for (int b = 0; b < 4; b++)
          if (ps[b]) mm[w][8*b +: 8] = pd[8*b +: 8];
      obs_rd = rData;
    end
    if (!inflight && !reset)
      for (int k = 1; k <= 2; k++)
        if (g < 0 && req[(last + k) % 2]) g = (last + k) % 2;
    if (g >= 0) eg = 2'(1 << g);
    chk("gnt", 64'(gnt), 64'(eg));
    chk("done", 64'(done), 64'(ed));
    chk("resp", 64'(resp), 64'(er));
    chk("rdata", 64'(rData), 64'(erd));
    chk("busy", 64'(busy), 64'(inflight));
    gport = g;
    if (reset) begin
      inflight = 1'b0;
      last = 1;
    end else begin
      if (inflight && cyc == due) inflight = 1'b0;
      if (g >= 0) begin
        inflight = 1'b1;
        due = cyc + 2;
        pp = g;
        last = g;
        pwr = write[g];
        pa = addr[g*32 +: 32];
        pd = wData[g*32 +: 32];
        ps = strb[g*4 +: 4];
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input int p, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    req[p] = 1'b1;
    write[p] = w;
    addr[p*32 +: 32] = a;
    wData[p*32 +: 32] = d;
    strb[p*4 +: 4] = s;
    n = 0;
    do begin
      cyc_step();
      n++;
    end while (gport != p && n < 20);
    chk("xfer_grant_timeout", 64'(n < 20), 64'd1);
    req[p] = 1'b0;
    n = 0;
    while (inflight && n < 20) begin
      cyc_step();
      n++;
    end
    chk("xfer_done_timeout", 64'(inflight), 64'd0);
  endtask
  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(7);
    if (r == 0) return 32'(32'h400 + 4 * $urandom_range(15));
    if (r == 1) return 32'(4 * $urandom_range(15) + $urandom_range(3, 1));
    return 32'(4 * $urandom_range(15));
  endfunction
  initial begin
    int n0, n1;
    logic [1:0] eg, ed;
    @(posedge clk);
    #1;
    cyc_step();
    chk("u1_reset_busy", 64'(busy1), 64'd0);
    chk("u1_reset_done", 64'(done1), 64'd0);
    reset = 1'b0;
    // zero-wait-state build: port 0 writes word 1, port 1 reads it, both held continuously
    req1 = 2'b11;
    write1 = 2'b01;
    addr1 = {32'h4, 32'h4};
    wData1 = {32'h0, 32'hCAFEF00D};
    strb1 = 8'h0F;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      eg = k % 2 == 0 ? 2'(1 << ((k / 2) % 2)) : 2'b00;
      ed = k % 2 == 1 ? 2'(1 << ((k / 2) % 2)) : 2'b00;
      chk("u1_gnt", 64'(gnt1), 64'(eg));
      chk("u1_done", 64'(done1), 64'(ed));
      chk("u1_busy", 64'(busy1), 64'(k % 2));
      chk("u1_resp", 64'(resp1), 64'd0);
      chk("u1_rdata", 64'(rData1), ed == 2'b10 ? 64'h0CAFEF00D : 64'd0);
      @(posedge clk);
      #1;
    end
    req1 = '0;
    for (int w = 0; w < 16; w++) xfer(w % 2, 1'b1, 32'(4 * w), $urandom, 4'hF);
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("rd_deadbeef", 64'(obs_rd), 64'hDEADBEEF);
    xfer(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("rd_partial", 64'(obs_rd), 64'hDEADBEAA);
    xfer(1, 1'b0, 32'h400, 32'h0, 4'h0);
    xfer(0, 1'b1, 32'h11, 32'h55555555, 4'hF);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("rd_after_err", 64'(obs_rd), 64'hDEADBEAA);
    // reset in the access cycle of a write aborts it
    xfer(0, 1'b1, 32'h20, 32'hA5A55A5A, 4'hF);
    req[0] = 1'b1; write[0] = 1'b1; addr[31:0] = 32'h20; wData[31:0] = 32'h12345678; strb[3:0] = 4'hF;
    cyc_step();
    chk("abort_gnt", 64'(gport), 64'd0);
    req[0] = 1'b0;
    reset = 1'b1;
    cyc_step();
    reset = 1'b0;
    cyc_step();
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0);
    chk("rd_after_abort", 64'(obs_rd), 64'hA5A55A5A);
    // both ports requesting continuously: 8 transfers in 24 cycles, shared equally
    req = 2'b11; write = 2'b00; addr = {32'h8, 32'hC};
    n0 = 0; n1 = 0;
    for (int c = 0; c < 24; c++) begin
      cyc_step();
      if (gport == 0) n0++;
      if (gport == 1) n1++;
    end
    chk("fair_p0", 64'(n0), 64'd4);
    chk("fair_p1", 64'(n1), 64'd4);
    req = 2'b00;
    for (int n = 0; n < 10 && inflight; n++) cyc_step();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++)
        if (req[p] && (gport == p || $urandom_range(15) == 0)) req[p] = 1'b0;
        else if (!req[p] && $urandom_range(2) != 0) begin
          req[p] = 1'b1;
          write[p] = 1'($urandom_range(1));
          addr[p*32 +: 32] = rand_addr();
          wData[p*32 +: 32] = $urandom;
          strb[p*4 +: 4] = 4'($urandom_range(15));
        end
      cyc_step();
    end
    req = 2'b00;
    for (int n = 0; n < 10; n++) cyc_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
